// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared state/requester encodings and width defaults
package ram_port_arbiter_pkg;
  localparam int DATA_SIZE_DEF = 16;
  localparam int ADDR_SIZE_DEF = 6;
  typedef enum logic {NORMAL, LOCKED} state_t;
  typedef enum logic [1:0] {ID_IF = 2'd0, ID_DM = 2'd1, ID_HOST = 2'd2} req_id_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester ports and RAM side of the arbiter
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int Data_Size = DATA_SIZE_DEF,
  parameter int Addr_Size = ADDR_SIZE_DEF
) ();
  logic                 IF_Req, IF_Gnt, IF_Rvalid;
  logic [Addr_Size-1:0] IF_Addr;
  logic                 DM_Req, DM_We, DM_Gnt, DM_Rvalid;
  logic [Addr_Size-1:0] DM_Addr;
  logic [Data_Size-1:0] DM_Wdata;
  logic                 HOST_Req, HOST_Lock, HOST_We, HOST_Gnt, HOST_Rvalid;
  logic [Addr_Size-1:0] HOST_Addr;
  logic [Data_Size-1:0] HOST_Wdata;
  logic                 Mem_En, Mem_We;
  logic [Addr_Size-1:0] Mem_Addr;
  logic [Data_Size-1:0] Mem_Wdata, Mem_Rdata, Rdata;
  logic                 Fetch_Stall;
  modport slave (
    input  IF_Req, IF_Addr, DM_Req, DM_We, DM_Addr, DM_Wdata,
           HOST_Req, HOST_Lock, HOST_We, HOST_Addr, HOST_Wdata, Mem_Rdata,
    output IF_Gnt, IF_Rvalid, DM_Gnt, DM_Rvalid, HOST_Gnt, HOST_Rvalid,
           Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Rdata, Fetch_Stall
  );
  modport master (
    output IF_Req, IF_Addr, DM_Req, DM_We, DM_Addr, DM_Wdata,
           HOST_Req, HOST_Lock, HOST_We, HOST_Addr, HOST_Wdata, Mem_Rdata,
    input  IF_Gnt, IF_Rvalid, DM_Gnt, DM_Rvalid, HOST_Gnt, HOST_Rvalid,
           Mem_En, Mem_We, Mem_Addr, Mem_Wdata, Rdata, Fetch_Stall
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick between DM (a) and HOST (b)
module rr_pick2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic gnt_a,
  input  logic gnt_b,
  output logic pick_b
);
  logic ptr;
  assign pick_b = req_b && (!req_a || ptr);
  // point at the port that did not just win
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (gnt_a || gnt_b) ptr <= gnt_a;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: single-port RAM arbiter for fetch, data and host-loader ports
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int Data_Size = DATA_SIZE_DEF,
  parameter int Addr_Size = ADDR_SIZE_DEF,
  parameter int Max_Wait  = 4
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);
  state_t               state;
  req_id_t              gid;
  logic [3:0]           wait_cnt;
  logic                 starve, pick_host, gv, if_rv, dm_rv, host_rv;
  logic [Addr_Size-1:0] addr_sel;
  logic [Data_Size-1:0] wdata_sel;
  assign starve = bus.IF_Req && wait_cnt == 4'(Max_Wait);
  rr_pick2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_a  (bus.DM_Req),
    .req_b  (bus.HOST_Req),
    .gnt_a  (bus.DM_Gnt),
    .gnt_b  (bus.HOST_Gnt),
    .pick_b (pick_host)
  );
  // pick the single winner for this cycle; starved fetch beats the round-robin pair
  always_comb begin
    gv  = 1'b0;
    gid = ID_IF;
    if (rst) gv = 1'b0;
    else if (state == LOCKED) begin
      gv  = bus.HOST_Req;
      gid = ID_HOST;
    end
    else if (starve) gv = 1'b1;
    else if (bus.DM_Req || bus.HOST_Req) begin
      gv  = 1'b1;
      gid = pick_host ? ID_HOST : ID_DM;
    end
    else gv = bus.IF_Req;
  end
  assign bus.IF_Gnt      = gv && gid == ID_IF;
  assign bus.DM_Gnt      = gv && gid == ID_DM;
  assign bus.HOST_Gnt    = gv && gid == ID_HOST;
  assign addr_sel        = gid == ID_DM ? bus.DM_Addr : gid == ID_HOST ? bus.HOST_Addr : bus.IF_Addr;
  assign wdata_sel       = gid == ID_HOST ? bus.HOST_Wdata : bus.DM_Wdata;
  assign bus.Mem_En      = gv;
  assign bus.Mem_We      = (bus.DM_Gnt && bus.DM_We) || (bus.HOST_Gnt && bus.HOST_We);
  assign bus.Mem_Addr    = addr_sel;
  assign bus.Mem_Wdata   = wdata_sel;
  assign bus.Rdata       = bus.Mem_Rdata;
  assign bus.Fetch_Stall = bus.IF_Req && !bus.IF_Gnt;
  assign bus.IF_Rvalid   = if_rv && !rst;
  assign bus.DM_Rvalid   = dm_rv && !rst;
  assign bus.HOST_Rvalid = host_rv && !rst;
  // lock FSM, fetch starvation counter and read-valid pipeline
  always_ff @(posedge clk)
    if (rst) begin
      state    <= NORMAL;
      wait_cnt <= 4'd0;
      if_rv    <= 1'b0;
      dm_rv    <= 1'b0;
      host_rv  <= 1'b0;
    end else begin
      state    <= state == NORMAL ? (bus.HOST_Gnt && bus.HOST_Lock ? LOCKED : NORMAL)
                                  : (bus.HOST_Lock ? LOCKED : NORMAL);
      wait_cnt <= (!bus.IF_Req || bus.IF_Gnt) ? 4'd0
                : wait_cnt == 4'(Max_Wait) ? wait_cnt : wait_cnt + 4'd1;
      if_rv    <= bus.IF_Gnt;
      dm_rv    <= bus.DM_Gnt && !bus.DM_We;
      host_rv  <= bus.HOST_Gnt && !bus.HOST_We;
    end
endmodule
